// File: rtl/multicycle_controller_if.sv
// Control bus between the multicycle ARM datapath and its controller.
// The datapath side presents the IR fields and live ALU flags; the controller
// side drives every select/enable plus the debug flags and state.
interface multicycle_controller_if #(
  parameter int STATE_W = 4
);
  logic [3:0]         Cond;
  logic [1:0]         Op;
  logic [5:0]         Funct;
  logic [3:0]         Rd;
  logic [3:0]         ALUFlags;

  logic               PCWrite;
  logic               AdrSrc;
  logic               MemWrite;
  logic               IRWrite;
  logic               RegWrite;
  logic [1:0]         ResultSrc;
  logic               ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [1:0]         ALUControl;
  logic [1:0]         ImmSrc;
  logic [1:0]         RegSrc;
  logic [3:0]         Flags;
  logic [STATE_W-1:0] State;

  modport master (
    output Cond, Op, Funct, Rd, ALUFlags,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc, Flags, State
  );

  modport slave (
    input  Cond, Op, Funct, Rd, ALUFlags,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc, Flags, State
  );
endinterface

// File: rtl/multicycle_controller.sv
// Main FSM, NZCV flags and condition check for the multicycle ARM datapath.
//
// state    | meaning
// FETCH    | read instruction at PC, load IR, PC <= PC+4
// DECODE   | read registers, latch condition result, compute PC+8
// MEMADR   | ALU forms load/store address Rn +/- imm
// MEMREAD  | read data memory at ALUOut
// MEMWB    | write loaded data to Rd (or PC)
// MEMWRITE | write Rd to data memory at ALUOut
// EXECR    | data-processing with register operand
// EXECI    | data-processing with immediate operand
// ALUWB    | write ALU result to Rd (or PC)
// BRANCH   | PC <= PC+8 + offset
//
// Outputs are registered from the next state, so the condition used for
// write enables must be the value cond_q is about to take when leaving DECODE.
module multicycle_controller #(
  parameter int STATE_W = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  multicycle_controller_if.slave bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic       r_cond_q;
  logic [3:0] r_flags;
  logic       w_cond_ex;
  logic       w_cond_next;
  logic [1:0] w_dp_ctl;
  logic       w_no_write;

  logic       r_pcwrite, r_adrsrc, r_memwrite, r_irwrite, r_regwrite, r_alusrca;
  logic [1:0] r_resultsrc, r_alusrcb, r_alucontrol;

  // Condition check against the registered NZCV flags
  always_comb begin
    logic n, z, c, v;
    {n, z, c, v} = r_flags;
    w_cond_ex = 1'b0;
    case (bus.Cond)
      4'b0000: w_cond_ex = z;
      4'b0001: w_cond_ex = ~z;
      4'b0010: w_cond_ex = c;
      4'b0011: w_cond_ex = ~c;
      4'b0100: w_cond_ex = n;
      4'b0101: w_cond_ex = ~n;
      4'b0110: w_cond_ex = v;
      4'b0111: w_cond_ex = ~v;
      4'b1000: w_cond_ex = c & ~z;
      4'b1001: w_cond_ex = ~c | z;
      4'b1010: w_cond_ex = (n == v);
      4'b1011: w_cond_ex = (n != v);
      4'b1100: w_cond_ex = ~z & (n == v);
      4'b1101: w_cond_ex = z | (n != v);
      4'b1110: w_cond_ex = 1'b1;
      default: w_cond_ex = 1'b0;
    endcase
  end

  // Data-processing decode; unknown commands run as ADD but never write back
  always_comb begin
    w_dp_ctl   = 2'b00;
    w_no_write = 1'b0;
    case (bus.Funct[4:1])
      4'b0000: w_dp_ctl = 2'b10;
      4'b1100: w_dp_ctl = 2'b11;
      4'b0100: w_dp_ctl = 2'b00;
      4'b0010: w_dp_ctl = 2'b01;
      4'b1010: begin w_dp_ctl = 2'b01; w_no_write = 1'b1; end
      default: begin w_dp_ctl = 2'b00; w_no_write = 1'b1; end
    endcase
  end

  assign w_cond_next = (r_state == S_DECODE) ? w_cond_ex : r_cond_q;

  // Next-state selection
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (bus.Op)
          2'b00:   w_next = bus.Funct[5] ? S_EXECI : S_EXECR;
          2'b01:   w_next = S_MEMADR;
          2'b10:   w_next = S_BRANCH;
          default: w_next = S_FETCH;
        endcase
      end
      S_MEMADR:   w_next = bus.Funct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  w_next = S_MEMWB;
      S_EXECR,
      S_EXECI:    w_next = S_ALUWB;
      default:    w_next = S_FETCH;
    endcase
  end

  // State, condition latch, flags and registered Moore outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= S_FETCH;
      r_cond_q     <= 1'b0;
      r_flags      <= 4'b0000;
      r_pcwrite    <= 1'b1;
      r_adrsrc     <= 1'b0;
      r_memwrite   <= 1'b0;
      r_irwrite    <= 1'b1;
      r_regwrite   <= 1'b0;
      r_resultsrc  <= 2'b10;
      r_alusrca    <= 1'b1;
      r_alusrcb    <= 2'b10;
      r_alucontrol <= 2'b00;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_cond_q <= w_cond_ex;
      if ((r_state == S_EXECR || r_state == S_EXECI) && r_cond_q && bus.Funct[0]) begin
        r_flags[3:2] <= bus.ALUFlags[3:2];
        if (!w_dp_ctl[1]) r_flags[1:0] <= bus.ALUFlags[1:0];
      end

      r_pcwrite    <= 1'b0;
      r_adrsrc     <= 1'b0;
      r_memwrite   <= 1'b0;
      r_irwrite    <= 1'b0;
      r_regwrite   <= 1'b0;
      r_resultsrc  <= 2'b00;
      r_alusrca    <= 1'b0;
      r_alusrcb    <= 2'b00;
      r_alucontrol <= 2'b00;
      case (w_next)
        S_FETCH: begin
          r_irwrite   <= 1'b1;
          r_pcwrite   <= 1'b1;
          r_alusrca   <= 1'b1;
          r_alusrcb   <= 2'b10;
          r_resultsrc <= 2'b10;
        end
        S_DECODE: begin
          r_alusrca   <= 1'b1;
          r_alusrcb   <= 2'b10;
          r_resultsrc <= 2'b10;
        end
        S_MEMADR: begin
          r_alusrcb    <= 2'b01;
          r_alucontrol <= bus.Funct[3] ? 2'b00 : 2'b01;
        end
        S_MEMREAD:  r_adrsrc <= 1'b1;
        S_MEMWRITE: begin
          r_adrsrc   <= 1'b1;
          r_memwrite <= w_cond_next;
        end
        S_MEMWB: begin
          r_resultsrc <= 2'b01;
          if (bus.Rd == 4'd15) r_pcwrite  <= w_cond_next;
          else                 r_regwrite <= w_cond_next;
        end
        S_EXECR: r_alucontrol <= w_dp_ctl;
        S_EXECI: begin
          r_alusrcb    <= 2'b01;
          r_alucontrol <= w_dp_ctl;
        end
        S_ALUWB: begin
          if (bus.Rd == 4'd15) r_pcwrite  <= w_cond_next & ~w_no_write;
          else                 r_regwrite <= w_cond_next & ~w_no_write;
        end
        S_BRANCH: begin
          r_alusrcb   <= 2'b01;
          r_resultsrc <= 2'b10;
          r_pcwrite   <= w_cond_next;
        end
        default: ;
      endcase
    end
  end

  // Write enables are held off for as long as reset is asserted
  assign bus.PCWrite    = r_pcwrite  & ~RST;
  assign bus.IRWrite    = r_irwrite  & ~RST;
  assign bus.RegWrite   = r_regwrite & ~RST;
  assign bus.MemWrite   = r_memwrite & ~RST;
  assign bus.AdrSrc     = r_adrsrc;
  assign bus.ResultSrc  = r_resultsrc;
  assign bus.ALUSrcA    = r_alusrca;
  assign bus.ALUSrcB    = r_alusrcb;
  assign bus.ALUControl = r_alucontrol;
  assign bus.ImmSrc     = bus.Op;
  assign bus.RegSrc     = {(bus.Op == 2'b01) & ~bus.Funct[0], bus.Op == 2'b10};
  assign bus.Flags      = r_flags;
  assign bus.State      = STATE_W'(r_state);

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed scenarios plus a
// random back-to-back instruction stream checked against a per-instruction model.
module tb_multicycle_controller;

  logic CLK;
  logic RST;
  multicycle_controller_if #(.STATE_W(4)) bus ();
  multicycle_controller #(.STATE_W(4)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  int n_vec = 0;
  int n_err = 0;
  logic [3:0] m_flags;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Expected control word {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,
  // ALUSrcA,ALUSrcB,ALUControl,ImmSrc,RegSrc} for a given step of an instruction
  function automatic logic [15:0] exp_ctl(input int st, input logic [1:0] op,
                                          input logic [5:0] fn, input logic [3:0] rd, input bit c);
    logic pcw, adr, mw, irw, rw, sa;
    logic [1:0] rs, sb, ac, dpc, rsrc;
    bit nw;
    pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; sa = 0; rs = 0; sb = 0; ac = 0;
    case (fn[4:1])
      4'b0000: begin dpc = 2'b10; nw = 0; end
      4'b1100: begin dpc = 2'b11; nw = 0; end
      4'b0100: begin dpc = 2'b00; nw = 0; end
      4'b0010: begin dpc = 2'b01; nw = 0; end
      4'b1010: begin dpc = 2'b01; nw = 1; end
      default: begin dpc = 2'b00; nw = 1; end
    endcase
    case (st)
      0: begin irw = 1; pcw = 1; sa = 1; sb = 2'b10; rs = 2'b10; end
      1: begin sa = 1; sb = 2'b10; rs = 2'b10; end
      2: begin sb = 2'b01; ac = fn[3] ? 2'b00 : 2'b01; end
      3: adr = 1;
      4: begin rs = 2'b01; if (rd == 15) pcw = c; else rw = c; end
      5: begin adr = 1; mw = c; end
      6: ac = dpc;
      7: begin sb = 2'b01; ac = dpc; end
      8: begin if (rd == 15) pcw = c && !nw; else rw = c && !nw; end
      9: begin sb = 2'b01; rs = 2'b10; pcw = c; end
      default: ;
    endcase
    rsrc = {op == 2'b01 && !fn[0], op == 2'b10};
    return {pcw, adr, mw, irw, rw, rs, sa, sb, ac, op, rsrc};
  endfunction

  // Runs one instruction from FETCH back to FETCH; entered and left at a negedge in FETCH
  task automatic run_instr(input string name, input logic [3:0] cond, input logic [1:0] op,
                           input logic [5:0] fn, input logic [3:0] rd, input bit rnd_af,
                           input logic [3:0] af, output bit obs_rw, output bit obs_pw,
                           output int obs_mw);
    int path[$];
    bit c;
    logic [3:0] a;
    logic [15:0] act, exp;
    bus.Cond = cond; bus.Op = op; bus.Funct = fn; bus.Rd = rd;
    c = cond_holds(cond, m_flags);
    path = {0, 1};
    case (op)
      2'b00: begin path.push_back(fn[5] ? 7 : 6); path.push_back(8); end
      2'b01: begin
        path.push_back(2);
        if (fn[0]) begin path.push_back(3); path.push_back(4); end
        else path.push_back(5);
      end
      2'b10: path.push_back(9);
      default: ;
    endcase
    obs_rw = 0; obs_pw = 0; obs_mw = 0;
    #1;
    foreach (path[k]) begin
      act = {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite, bus.ResultSrc,
             bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl, bus.ImmSrc, bus.RegSrc};
      exp = exp_ctl(path[k], op, fn, rd, c);
      n_vec++;
      if (bus.State !== 4'(path[k]) || act !== exp || bus.Flags !== m_flags) begin
        n_err++;
        $display("FAIL %s step %0d: state=%0d ctl=%b flags=%b, required state=%0d ctl=%b flags=%b",
                 name, k, bus.State, act, bus.Flags, path[k], exp, m_flags);
      end
      if (path[k] == 4 || path[k] == 8 || path[k] == 9) begin
        obs_rw = bus.RegWrite;
        obs_pw = bus.PCWrite;
      end
      obs_mw += int'(bus.MemWrite);
      a = rnd_af ? 4'($urandom) : af;
      bus.ALUFlags = a;
      if ((path[k] == 6 || path[k] == 7) && c && fn[0]) begin
        m_flags[3:2] = a[3:2];
        if (fn[4:1] != 4'b0000 && fn[4:1] != 4'b1100) m_flags[1:0] = a[1:0];
      end
      @(negedge CLK);
      #1;
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    bus.Cond = 4'hE; bus.Op = 2'b00; bus.Funct = 6'h0; bus.Rd = 4'h0; bus.ALUFlags = 4'hF;
    repeat (2) @(negedge CLK);
    n_vec++;
    if (bus.State !== 4'd0 || bus.Flags !== 4'd0 ||
        {bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_hold: state=%0d flags=%b we=%b, required 0 0000 0000",
               bus.State, bus.Flags, {bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite});
    end
    RST = 1'b0;
    m_flags = 4'b0000;
  endtask

  task automatic test_dp_al();
    bit rw, pw; int mw;
    run_instr("dp_al_addi", 4'b1110, 2'b00, 6'b101000, 4'd4, 1'b0, 4'b0000, rw, pw, mw);
    n_vec++;
    if (rw !== 1'b1) begin n_err++; $display("FAIL dp_al_regwrite: got %b want 1", rw); end
  endtask

  task automatic test_cmp_flags();
    bit rw, pw; int mw;
    run_instr("cmp", 4'b1110, 2'b00, 6'b010101, 4'd2, 1'b0, 4'b0100, rw, pw, mw);
    n_vec++;
    if (bus.Flags !== 4'b0100 || rw !== 1'b0) begin
      n_err++;
      $display("FAIL cmp_flags: flags=%b rw=%b, required 0100 0", bus.Flags, rw);
    end
  endtask

  task automatic test_cond();
    bit rw, pw; int mw;
    run_instr("cond_ne", 4'b0001, 2'b00, 6'b001000, 4'd5, 1'b0, 4'b0000, rw, pw, mw);
    n_vec++;
    if (rw !== 1'b0) begin n_err++; $display("FAIL cond_ne_regwrite: got %b want 0", rw); end
    run_instr("cond_ls", 4'b1001, 2'b00, 6'b001000, 4'd5, 1'b0, 4'b0000, rw, pw, mw);
    n_vec++;
    if (rw !== 1'b1) begin n_err++; $display("FAIL cond_ls_regwrite: got %b want 1", rw); end
  endtask

  task automatic test_flag_iso();
    bit rw, pw; int mw;
    run_instr("subs_eq", 4'b0000, 2'b00, 6'b000101, 4'd6, 1'b0, 4'b0000, rw, pw, mw);
    n_vec++;
    if (rw !== 1'b1 || bus.Flags !== 4'b0000) begin
      n_err++;
      $display("FAIL flag_iso: rw=%b flags=%b, required 1 0000", rw, bus.Flags);
    end
  endtask

  task automatic test_memory();
    bit rw, pw; int mw;
    run_instr("ldr", 4'b1110, 2'b01, 6'b011001, 4'd3, 1'b1, 4'b0000, rw, pw, mw);
    n_vec++;
    if (rw !== 1'b1) begin n_err++; $display("FAIL ldr_regwrite: got %b want 1", rw); end
    bus.Funct = 6'b011000;
    #1;
    n_vec++;
    if (bus.RegSrc !== 2'b10) begin n_err++; $display("FAIL str_regsrc: got %b want 10", bus.RegSrc); end
    run_instr("str", 4'b1110, 2'b01, 6'b011000, 4'd3, 1'b1, 4'b0000, rw, pw, mw);
    n_vec++;
    if (mw != 1) begin n_err++; $display("FAIL str_memwrite_cycles: got %0d want 1", mw); end
  endtask

  task automatic test_branch_pc();
    bit rw, pw; int mw;
    run_instr("branch", 4'b1110, 2'b10, 6'b110011, 4'd0, 1'b1, 4'b0000, rw, pw, mw);
    n_vec++;
    if (pw !== 1'b1) begin n_err++; $display("FAIL branch_pcwrite: got %b want 1", pw); end
    run_instr("add_pc", 4'b1110, 2'b00, 6'b001000, 4'd15, 1'b0, 4'b0000, rw, pw, mw);
    n_vec++;
    if (pw !== 1'b1 || rw !== 1'b0) begin
      n_err++;
      $display("FAIL add_pc: pw=%b rw=%b, required 1 0", pw, rw);
    end
  endtask

  task automatic test_reset_mid();
    bit rw, pw; int mw;
    int seen_mw;
    bus.Cond = 4'b1110; bus.Op = 2'b01; bus.Funct = 6'b011000; bus.Rd = 4'd7;
    repeat (2) @(negedge CLK);
    #1;
    n_vec++;
    if (bus.State !== 4'd2) begin n_err++; $display("FAIL rst_mid_pre: state=%0d want 2", bus.State); end
    RST = 1'b1;
    #1;
    n_vec++;
    if (bus.State !== 4'd0 || bus.MemWrite !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_async: state=%0d mw=%b, required 0 0", bus.State, bus.MemWrite);
    end
    seen_mw = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      seen_mw += int'(bus.MemWrite);
    end
    RST = 1'b0;
    m_flags = 4'b0000;
    n_vec++;
    if (seen_mw != 0) begin n_err++; $display("FAIL rst_mid_memwrite: got %0d want 0", seen_mw); end
    run_instr("after_rst", 4'b1110, 2'b00, 6'b111000, 4'd1, 1'b1, 4'b0000, rw, pw, mw);
  endtask

  task automatic test_back_to_back();
    bit rw, pw; int mw;
    for (int i = 0; i < 80; i++) begin
      run_instr("random", 4'($urandom), 2'($urandom), 6'($urandom), 4'($urandom),
                1'b1, 4'b0000, rw, pw, mw);
    end
  endtask

  initial begin
    m_flags = 4'b0000;
    test_reset();
    test_dp_al();
    test_cmp_flags();
    test_cond();
    test_flag_iso();
    test_memory();
    test_branch_pc();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
